// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access controller.
//   - op-code constants (codes 9..15 are treated as NOP)
//   - FSM state encoding
//   - bus payload struct
//   - op classification, byte-enable and store-lane helpers
package mem_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [OP_W-1:0] OP_NOP = 4'd0;
    localparam logic [OP_W-1:0] OP_LB  = 4'd1;
    localparam logic [OP_W-1:0] OP_LBU = 4'd2;
    localparam logic [OP_W-1:0] OP_LH  = 4'd3;
    localparam logic [OP_W-1:0] OP_LHU = 4'd4;
    localparam logic [OP_W-1:0] OP_LW  = 4'd5;
    localparam logic [OP_W-1:0] OP_SB  = 4'd6;
    localparam logic [OP_W-1:0] OP_SH  = 4'd7;
    localparam logic [OP_W-1:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Write-side payload latched when a transaction starts
    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } bus_payload_t;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic is_half(input logic [OP_W-1:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // Little-endian lane enables for an aligned access at byte offset off
    function automatic logic [BE_W-1:0] byte_enable(input logic [OP_W-1:0] op,
                                                    input logic [1:0]      off);
        logic [BE_W-1:0] be;
        be = '0;
        case (op)
            OP_LB, OP_LBU, OP_SB: be = BE_W'(4'b0001 << off);
            OP_LH, OP_LHU, OP_SH: be = off[1] ? 4'b1100 : 4'b0011;
            OP_LW, OP_SW:         be = 4'b1111;
            default:              be = '0;
        endcase
        return be;
    endfunction

    // Store data replicated across lanes so the enabled lanes carry it
    function automatic logic [DATA_W-1:0] store_lanes(input logic [OP_W-1:0]   op,
                                                      input logic [DATA_W-1:0] sd);
        logic [DATA_W-1:0] wd;
        wd = '0;
        case (op)
            OP_SB:   wd = {4{sd[7:0]}};
            OP_SH:   wd = {2{sd[15:0]}};
            OP_SW:   wd = sd;
            default: wd = '0;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load-data alignment: selects the byte/halfword at the access offset from
// the bus word and sign- or zero-extends it.
//   op    : load op code (LB/LBU/LH/LHU/LW)
//   off   : byte offset within the word
//   rdata : raw bus read word
//   data  : extended load result (combinational)
module load_align
    import mem_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select
    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension
    always_comb begin
        data = rdata;
        case (op)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'd0, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: turns a pipeline load/store into a
// word-aligned, byte-enabled request/ack bus transaction and stalls the
// pipeline until it completes or times out.
//   clk, rst        : clock, synchronous active-high reset
//   memOp_i         : op code, virtualAddr_i : effective address
//   storeData_i     : store source, busRdata_i/busAck_i : bus response
//   busReq_o/We/Be/Addr/Wdata : registered bus request
//   loadData_o      : registered extended load result
//   pauseRequest_o  : pipeline stall (combinational)
//   addrErr_o       : misaligned access (combinational)
//   busErr_o        : one-cycle timeout pulse
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   memOp_i,
    input  logic [ADDR_W-1:0] virtualAddr_i,
    input  logic [DATA_W-1:0] storeData_i,
    input  logic [DATA_W-1:0] busRdata_i,
    input  logic              busAck_i,
    output logic              busReq_o,
    output logic              busWe_o,
    output logic [BE_W-1:0]   busBe_o,
    output logic [ADDR_W-1:0] busAddr_o,
    output logic [DATA_W-1:0] busWdata_o,
    output logic [DATA_W-1:0] loadData_o,
    output logic              pauseRequest_o,
    output logic              addrErr_o,
    output logic              busErr_o
);

    localparam int unsigned     CNT_P1_W    = CNT_W + 1;
    localparam logic [CNT_W:0]  TIMEOUT_VAL = CNT_P1_W'(TIMEOUT_CYCLES);

    state_t            state;
    state_t            next_state;
    logic [1:0]        off;
    logic              op_valid;
    logic              misaligned;
    logic              start;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W:0]    cnt_inc;
    logic              timeout_hit;
    logic [OP_W-1:0]   op_q;
    logic [OP_W-1:0]   op_d;
    logic [1:0]        off_q;
    logic [1:0]        off_d;
    logic              req_d;
    bus_payload_t      pay_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] load_d;
    logic              err_d;
    logic [DATA_W-1:0] aligned_data;

    // Request decode
    assign off        = virtualAddr_i[1:0];
    assign op_valid   = is_load(memOp_i) || is_store(memOp_i);
    assign misaligned = (is_half(memOp_i) && off[0]) || (is_word(memOp_i) && (off != 2'b00));
    assign start      = (state == ST_IDLE) && op_valid && !misaligned;

    // Counter value after the current REQ cycle; the ack takes priority over a timeout
    assign cnt_inc     = CNT_P1_W'(cnt) + CNT_P1_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_VAL);

    load_align u_load_align (
        .op    (op_q),
        .off   (off_q),
        .rdata (busRdata_i),
        .data  (aligned_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_REQ;
            ST_REQ:  if (busAck_i || timeout_hit) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Output logic: combinational stall/error plus next values of registered outputs
    always_comb begin
        pauseRequest_o = !rst && (start || (state == ST_REQ));
        addrErr_o      = !rst && (state == ST_IDLE) && op_valid && misaligned;
        req_d          = 1'b0;
        pay_d          = '{we: busWe_o, be: busBe_o, wdata: busWdata_o};
        addr_d         = busAddr_o;
        op_d           = op_q;
        off_d          = off_q;
        load_d         = loadData_o;
        err_d          = 1'b0;
        cnt_d          = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    req_d  = 1'b1;
                    pay_d  = '{we:    is_store(memOp_i),
                               be:    byte_enable(memOp_i, off),
                               wdata: store_lanes(memOp_i, storeData_i)};
                    addr_d = {virtualAddr_i[ADDR_W-1:2], 2'b00};
                    op_d   = memOp_i;
                    off_d  = off;
                    cnt_d  = '0;
                end
            end
            ST_REQ: begin
                cnt_d = CNT_W'(cnt_inc);
                if (busAck_i || timeout_hit) begin
                    // Transaction over: release the bus fields
                    pay_d  = '0;
                    addr_d = '0;
                    if (busAck_i) begin
                        if (is_load(op_q)) load_d = aligned_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    req_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Registered outputs and transaction context
    always_ff @(posedge clk) begin
        if (rst) begin
            busReq_o   <= 1'b0;
            busWe_o    <= 1'b0;
            busBe_o    <= '0;
            busAddr_o  <= '0;
            busWdata_o <= '0;
            loadData_o <= '0;
            busErr_o   <= 1'b0;
            cnt        <= '0;
            op_q       <= OP_NOP;
            off_q      <= 2'b00;
        end else begin
            busReq_o   <= req_d;
            busWe_o    <= pay_d.we;
            busBe_o    <= pay_d.be;
            busAddr_o  <= addr_d;
            busWdata_o <= pay_d.wdata;
            loadData_o <= load_d;
            busErr_o   <= err_d;
            cnt        <= cnt_d;
            op_q       <= op_d;
            off_q      <= off_d;
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller for the MIPS32 pipeline: converts the MEM-stage load/store request into a word-aligned, byte-enabled transaction on a multi-cycle memory bus with a request/acknowledge handshake. It stalls the pipeline with `pauseRequest_o` until the transaction completes or times out. It detects misaligned halfword/word accesses and sign/zero-extends load data. It sits between the EX/MEM pipeline register and the memory/bus arbiter.

## Interface
Parameters:
- `ADDR_W`, 32: width of `virtualAddr_i` and `busAddr_o`.
- `TIMEOUT_CYCLES`, 255: maximum number of REQ cycles without an ack before a bus error; 0 disables the timeout.
- `CNT_W`, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `memOp_i`  in  4  operation code (see package).
- `virtualAddr_i`  in  ADDR_W  effective address.
- `storeData_i`  in  32  store source register value.
- `busRdata_i`  in  32  read data, valid when `busAck_i`=1.
- `busAck_i`  in  1  transaction complete.
- `busReq_o`  out  1  request, held until ack.
- `busWe_o`  out  1  1 = write.
- `busBe_o`  out  4  byte enables, lane n = bits [8n+7:8n].
- `busAddr_o`  out  ADDR_W  word address, bits [1:0] = 0.
- `busWdata_o`  out  32  lane-replicated store data.
- `loadData_o`  out  32  extended load result, registered.
- `pauseRequest_o`  out  1  stall pipeline.
- `addrErr_o`  out  1  misaligned access (AdEL/AdES), combinational.
- `busErr_o`  out  1  timeout pulse, one cycle.

## Operation
- Op codes: NOP=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8. Codes 9–15 are treated as NOP.
- Alignment:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - On violation: `addrErr_o`=1 in the same cycle, no bus request, `pauseRequest_o`=0, FSM stays in IDLE.
- Byte enables (little-endian, `off`=addr[1:0]):
  - Byte ops: 1<<off.
  - Halfword ops: 0011 for off=0, 1100 for off=2.
  - Word ops: 1111.
- Store data:
  - SB: {4{storeData_i[7:0]}}.
  - SH: {2{storeData_i[15:0]}}.
  - SW: storeData_i.
- Load extraction: select the byte/halfword at `off` from `busRdata_i`. LB/LH sign-extend; LBU/LHU zero-extend.
- FSM:
  - IDLE: on a valid aligned op, `pauseRequest_o`=1 combinationally; latch addr/be/we/wdata; go to REQ.
  - REQ: `busReq_o`=1; outputs held stable; `pauseRequest_o`=1; counter increments each cycle.
    - If `busAck_i`: latch `loadData_o` (loads only); go to DONE.
    - Else, if the counter reaches TIMEOUT_CYCLES: drop the request, pulse `busErr_o`, go to DONE.
  - DONE: `pauseRequest_o`=0 so the pipeline advances; no request is issued even though `memOp_i` still shows the same op; next state is IDLE.
- `loadData_o` holds its value until the next completed load. It is unchanged on a store, a timeout, or a misaligned access.

## Timing
- Reset: all outputs 0; FSM in IDLE; counter 0.
- Minimum access (ack in the first REQ cycle): `pauseRequest_o` high for 2 cycles; the instruction leaves MEM on the 3rd cycle.
- Each cycle of ack delay adds one cycle of stall.
- `busReq_o` rises on the clock edge after the op appears in IDLE.
- `busAck_i` is sampled only in REQ; an ack in IDLE or DONE is ignored.
- Ack in the same cycle the counter reaches TIMEOUT_CYCLES: the ack wins and `busErr_o` stays 0.
- `rst` during REQ: `busReq_o` is 0 after that edge; no DONE state; `loadData_o` is cleared.

## Structure
- Shared package `mem_pkg`: op-code localparams, FSM state encoding, and an `is_load`/`is_store` helper function.
- One natural sub-module, `load_align`: combinational byte/halfword select plus extension, reused later by the LWL/LWR extension.
- Everything else lives in the top module.

## Test plan
- LW, addr 0x8000_0010, ack after 3 REQ cycles, rdata 0xDEAD_BEEF -> `busBe_o`=1111, `busAddr_o`=0x8000_0010; `pauseRequest_o` high for 4 cycles; `loadData_o`=0xDEAD_BEEF.
- LB at addr 0x…03, rdata 0x80xx_xxxx -> `busBe_o`=1000, `loadData_o`=0xFFFF_FF80. LBU on the same access -> 0x0000_0080.
- SH, addr 0x…02, storeData_i 0x1234_ABCD -> `busWe_o`=1, `busBe_o`=1100, `busWdata_o`=0xABCD_ABCD, `busAddr_o` bits [1:0]=00.
- LW at addr 0x…02 -> `addrErr_o`=1 the same cycle; `busReq_o` and `pauseRequest_o` stay 0; `loadData_o` unchanged.
- TIMEOUT_CYCLES=4, no ack -> `busReq_o` high for 4 cycles, then a 1-cycle `busErr_o` pulse in DONE, then IDLE.
- `rst` asserted during the 2nd REQ cycle -> all outputs 0 on the next cycle; a late ack is ignored; a new LW afterwards completes normally.
